// File: rtl/ad_ip_jesd204_tpl_adc_pack.sv
// Packs enabled-channel samples from the JESD204 ADC transport layer into full DMA words.
// ADC_PACK_OVERFLOW_STICKY_EN makes fifo_wr_overflow sticky until the next sync word.
module ad_ip_jesd204_tpl_adc_pack #(
  parameter int NUM_CHANNELS      = 4,
  parameter int DATA_PATH_WIDTH   = 1,
  parameter int SAMPLE_DATA_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic fifo_wr_en,
  input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_DATA_WIDTH-1:0] fifo_wr_data,
  output logic fifo_wr_overflow,
  output logic packed_fifo_wr_en,
  output logic [NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_DATA_WIDTH-1:0] packed_fifo_wr_data,
  output logic packed_fifo_wr_sync,
  input  logic packed_fifo_wr_overflow,
  output logic cfg_error
);

  localparam int W  = NUM_CHANNELS * DATA_PATH_WIDTH;
  localparam int SW = SAMPLE_DATA_WIDTH;
  localparam int DW = W * SW;
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0] enable_r;
  logic [NUM_CHANNELS-1:0] enable_p;
  logic [CW-1:0] cnt;
  logic [CW-1:0] k;
  logic [DW-1:0] acc;
  logic [DW-1:0] word;
  logic sync_flag;
  logic chg;
  logic accept;
  logic last;
  logic emit_sync;
  int unsigned e;
  int unsigned base;
  int unsigned rank [NUM_CHANNELS];

  always_comb begin
    e = 0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rank[c] = e;
      e = e + 32'(enable_r[c]);
    end
  end

  assign cfg_error = (e == 0) || ((e & (e - 1)) != 0);
  assign chg       = enable_r != enable_p;
  assign accept    = fifo_wr_en && !cfg_error;
  assign k         = chg ? '0 : cnt;
  assign last      = ((32'(k) + 1) * e) == NUM_CHANNELS;
  assign emit_sync = accept && last && (sync_flag || chg);

  // Slot of (c,s) in the word: beat offset + s*E + rank of c among enabled.
  always_comb begin
    word = acc;
    base = 32'(k) * e * DATA_PATH_WIDTH;
    for (int j = 0; j < W; j++) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int s = 0; s < DATA_PATH_WIDTH; s++) begin
          if (enable_r[c] &&
              (base + s * e + rank[c]) == j)
            word[j*SW +: SW] =
              fifo_wr_data[(c*DATA_PATH_WIDTH+s)*SW +: SW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_r            <= '0;
      enable_p            <= '0;
      cnt                 <= '0;
      acc                 <= '0;
      sync_flag           <= 1'b1;
      packed_fifo_wr_en   <= 1'b0;
      packed_fifo_wr_sync <= 1'b0;
      packed_fifo_wr_data <= '0;
    end else begin
      enable_r            <= enable;
      enable_p            <= enable_r;
      packed_fifo_wr_en   <= 1'b0;
      packed_fifo_wr_sync <= 1'b0;
      if (chg)
        sync_flag <= 1'b1;
      if (cfg_error) begin
        cnt <= '0;
      end else if (accept) begin
        if (last) begin
          cnt                 <= '0;
          packed_fifo_wr_en   <= 1'b1;
          packed_fifo_wr_data <= word;
          packed_fifo_wr_sync <= sync_flag || chg;
          sync_flag           <= 1'b0;
        end else begin
          cnt <= k + 1'b1;
          acc <= word;
        end
      end else if (chg) begin
        cnt <= '0;
      end
    end
  end

`ifdef ADC_PACK_OVERFLOW_STICKY_EN
  // A new overflow wins over the clear from a sync word.
  always_ff @(posedge clk) begin
    if (reset)
      fifo_wr_overflow <= 1'b0;
    else if (packed_fifo_wr_overflow)
      fifo_wr_overflow <= 1'b1;
    else if (emit_sync)
      fifo_wr_overflow <= 1'b0;
  end
`else
  always_ff @(posedge clk) begin
    if (reset)
      fifo_wr_overflow <= 1'b0;
    else
      fifo_wr_overflow <= packed_fifo_wr_overflow;
  end

  logic unused_emit;
  assign unused_emit = emit_sync;
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pack.sv
// Self-checking bench for ad_ip_jesd204_tpl_adc_pack (4 ch, 1 sample/beat, 16 bit).
// Queue-based sample model plus literal word checks from the directed vectors.
module tb_ad_ip_jesd204_tpl_adc_pack;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] enable = '0;
  logic fifo_wr_en = 1'b0;
  logic [DW-1:0] fifo_wr_data = '0;
  logic fifo_wr_overflow;
  logic packed_fifo_wr_en;
  logic [DW-1:0] packed_fifo_wr_data;
  logic packed_fifo_wr_sync;
  logic packed_fifo_wr_overflow = 1'b0;
  logic cfg_error;

  int checks = 0;
  int errors = 0;

  ad_ip_jesd204_tpl_adc_pack #(
    .NUM_CHANNELS(N),
    .DATA_PATH_WIDTH(1),
    .SAMPLE_DATA_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .fifo_wr_overflow(fifo_wr_overflow),
    .packed_fifo_wr_en(packed_fifo_wr_en),
    .packed_fifo_wr_data(packed_fifo_wr_data),
    .packed_fifo_wr_sync(packed_fifo_wr_sync),
    .packed_fifo_wr_overflow(packed_fifo_wr_overflow),
    .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  // Model: enabled samples queue up in arrival order; a full queue is a word.
  logic [N-1:0] m_en_r, m_en_p;
  logic [15:0] q[$];
  logic m_sync;
  logic e_en, e_sync, e_ovf;
  logic [DW-1:0] e_data;
  logic [64:0] cap[$];

  always @(posedge clk) begin
    if (reset) begin
      m_en_r = '0;
      m_en_p = '0;
      q.delete();
      m_sync = 1'b1;
      e_en = 1'b0;
      e_sync = 1'b0;
      e_data = '0;
      e_ovf = 1'b0;
    end else begin
      int ne;
      bit err;
      ne = $countones(m_en_r);
      err = (ne == 0) || ((ne & (ne - 1)) != 0);
      if (m_en_r != m_en_p) begin
        q.delete();
        m_sync = 1'b1;
      end
      if (err)
        q.delete();
      e_en = 1'b0;
      e_sync = 1'b0;
      if (fifo_wr_en && !err) begin
        for (int c = 0; c < N; c++)
          if (m_en_r[c])
            q.push_back(fifo_wr_data[c*16 +: 16]);
        if (q.size() == W) begin
          for (int i = 0; i < W; i++)
            e_data[i*16 +: 16] = q[i];
          e_en = 1'b1;
          e_sync = m_sync;
          m_sync = 1'b0;
          q.delete();
        end
      end
`ifdef ADC_PACK_OVERFLOW_STICKY_EN
      if (packed_fifo_wr_overflow)
        e_ovf = 1'b1;
      else if (e_en && e_sync)
        e_ovf = 1'b0;
`else
      e_ovf = packed_fifo_wr_overflow;
`endif
      m_en_p = m_en_r;
      m_en_r = enable;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      int ne;
      logic x_err;
      @(negedge clk);
      ne = $countones(m_en_r);
      x_err = (ne == 0) || ((ne & (ne - 1)) != 0);
      checks++;
      if (packed_fifo_wr_en !== e_en) begin
        errors++;
        $display("FAIL wr_en t=%0t got %b want %b", $time, packed_fifo_wr_en, e_en);
      end
      checks++;
      if (cfg_error !== x_err) begin
        errors++;
        $display("FAIL cfg_error t=%0t got %b want %b", $time, cfg_error, x_err);
      end
      checks++;
      if (fifo_wr_overflow !== e_ovf) begin
        errors++;
        $display("FAIL overflow t=%0t got %b want %b", $time, fifo_wr_overflow, e_ovf);
      end
      if (reset || e_en) begin
        checks++;
        if (packed_fifo_wr_data !== e_data || (e_en && packed_fifo_wr_sync !== e_sync)) begin
          errors++;
          $display("FAIL word t=%0t got %b/%h want %b/%h", $time,
                   packed_fifo_wr_sync, packed_fifo_wr_data, e_sync, e_data);
        end
      end
      if (packed_fifo_wr_en)
        cap.push_back({packed_fifo_wr_sync, packed_fifo_wr_data});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d);
    fifo_wr_en = 1'b1;
    fifo_wr_data = d;
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b0;
  endtask

  task automatic chk_word(input string name, input int idx, input logic [64:0] exp);
    checks++;
    if (cap.size() <= idx) begin
      errors++;
      $display("FAIL %s got no word #%0d want %h", name, idx, exp);
    end else if (cap[idx] !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, cap[idx], exp);
    end
  endtask

  task automatic chk_count(input string name, input int exp);
    checks++;
    if (cap.size() != exp) begin
      errors++;
      $display("FAIL %s got %0d words want %0d", name, cap.size(), exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, exp);
    end
  endtask

  logic [N-1:0] en_tab [12] = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3,
                                4'h5, 4'hA, 4'hC, 4'h6, 4'h7, 4'h0};

  initial begin
    int base;
    idle(3);
    chk_bit("reset_cfg_error", cfg_error, 1'b1);
    chk_bit("reset_wr_en", packed_fifo_wr_en, 1'b0);
    reset = 1'b0;

    enable = 4'hF;
    idle(2);
    beat(64'h0004_0003_0002_0001);
    beat(64'h0008_0007_0006_0005);
    idle(2);
    chk_word("passthru_first", 0, {1'b1, 64'h0004_0003_0002_0001});
    chk_word("passthru_second", 1, {1'b0, 64'h0008_0007_0006_0005});

    base = cap.size();
    enable = 4'b0101;
    idle(2);
    beat(64'h00D4_00C3_00B2_00A1);
    idle(1);
    chk_count("half_word_none", base);
    beat(64'h00E4_00D3_00C2_00B1);
    idle(2);
    chk_count("two_ch_one_word", base + 1);
    chk_word("two_ch_word", base, {1'b1, 64'h00D3_00B1_00C3_00A1});

    base = cap.size();
    enable = 4'b0001;
    idle(2);
    for (int i = 1; i <= 8; i++)
      beat({16'hBEEF, 16'hCAFE, 16'h5A5A, 16'(i)});
    idle(2);
    chk_word("one_ch_w0", base, {1'b1, 64'h0004_0003_0002_0001});
    chk_word("one_ch_w1", base + 1, {1'b0, 64'h0008_0007_0006_0005});

    base = cap.size();
    enable = 4'b0011;
    idle(2);
    beat(64'h0000_0000_0002_0001);
    enable = 4'hF;
    idle(1);
    beat(64'h1111_2222_3333_4444);
    idle(2);
    chk_count("chg_discard", base + 1);
    chk_word("chg_word", base, {1'b1, 64'h1111_2222_3333_4444});

    base = cap.size();
    enable = 4'b0111;
    idle(2);
    chk_bit("three_ch_error", cfg_error, 1'b1);
    for (int i = 0; i < 10; i++)
      beat({16'(i), 16'(i + 1), 16'(i + 2), 16'(i + 3)});
    chk_count("error_no_words", base);
    enable = 4'b0011;
    idle(2);
    chk_bit("two_ch_ok", cfg_error, 1'b0);
    beat(64'h0000_0000_0022_0011);
    beat(64'h0000_0000_0044_0033);
    idle(2);
    chk_word("resume_word", base, {1'b1, 64'h0044_0033_0022_0011});

    base = cap.size();
    beat(64'h0000_0000_0002_0001);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(3);
    beat(64'h0000_0000_0006_0005);
    beat(64'h0000_0000_0008_0007);
    idle(2);
    chk_word("reset_mid_word", base, {1'b1, 64'h0008_0007_0006_0005});

    packed_fifo_wr_overflow = 1'b1;
    @(posedge clk);
    #1;
    packed_fifo_wr_overflow = 1'b0;
    @(negedge clk);
    chk_bit("ovf_first", fifo_wr_overflow, 1'b1);
    @(negedge clk);
`ifdef ADC_PACK_OVERFLOW_STICKY_EN
    chk_bit("ovf_hold", fifo_wr_overflow, 1'b1);
`else
    chk_bit("ovf_pulse_end", fifo_wr_overflow, 1'b0);
`endif
    idle(1);
    beat(64'h0000_0000_0002_0001);
    beat(64'h0000_0000_0004_0003);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0)
        enable = en_tab[$urandom_range(0, 11)];
      fifo_wr_en = ($urandom_range(0, 3) != 0);
      fifo_wr_data = {$urandom, $urandom};
      packed_fifo_wr_overflow = ($urandom_range(0, 24) == 0);
      reset = (i == 200);
      @(posedge clk);
      #1;
    end
    fifo_wr_en = 1'b0;
    packed_fifo_wr_overflow = 1'b0;
    reset = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
